// File: rtl/fifo_pkg.sv
// Shared sizing helpers for sync_fifo_prog: depth/pointer-width derivation and
// threshold legality used by the top-level elaboration check.
package fifo_pkg;

  function automatic int fifo_depth(input int addrsize);
    return 2 ** addrsize;
  endfunction

  // One extra wrap bit distinguishes full from empty when the pointers are equal.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic bit levels_legal(input int addrsize, input int af, input int ae);
    return (af >= 0) && (af < fifo_depth(addrsize)) &&
           (ae >= 0) && (ae < fifo_depth(addrsize));
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DATESIZE x DEPTH register array: one synchronous write port and one
// combinational read address; the top decides whether the read is registered.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DATESIZE = 8,
  parameter int ADDRSIZE = 3
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATESIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATESIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);

  logic [DATESIZE-1:0] mem [DEPTH];

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty levels, occupancy count,
// sticky overflow/underflow and synchronous flush. SYNC_FIFO_FWFT_EN selects first-word-fall-through.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATESIZE = 8,
  parameter int ADDRSIZE = 3,
  parameter int AF_LEVEL = 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic [DATESIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  output logic [DATESIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam int PW    = ptr_width(ADDRSIZE);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_THR  = PW'(DEPTH - AF_LEVEL);
  localparam logic [PW-1:0] AE_THR  = PW'(AE_LEVEL);
  localparam logic          AF_RST  = (AF_LEVEL >= DEPTH);

  if (!levels_legal(ADDRSIZE, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("sync_fifo_prog: AF_LEVEL/AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PW-1:0]       wptr, rptr, count_nxt;
  logic                wr_acc, rd_acc;
  logic [DATESIZE-1:0] rd_word;

  // Flush wins over both requests, so nothing moves and no error is raised.
  assign wr_acc    = winc && !wfull  && !flush;
  assign rd_acc    = rinc && !rempty && !flush;
  assign count_nxt = flush ? '0 : count + PW'(wr_acc) - PW'(rd_acc);

  fifo_dpram #(.DATESIZE(DATESIZE), .ADDRSIZE(ADDRSIZE)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= flush ? '0 : wptr + PW'(wr_acc);
      rptr         <= flush ? '0 : rptr + PW'(rd_acc);
      count        <= count_nxt;
      wfull        <= (count_nxt == DEPTH_C);
      rempty       <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_THR);
      almost_empty <= (count_nxt <= AE_THR);
      overflow     <= !flush && (overflow  || (winc && wfull));
      underflow    <= !flush && (underflow || (rinc && rempty));
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = rd_word;
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       rdata <= '0;
    else if (rd_acc) rdata <= rd_word;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed steps plus random traffic,
// compared against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 8;
  localparam int AF    = 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         m_ov = 1'b0;
  bit         m_uf = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  sync_fifo_prog #(.DATESIZE(8), .ADDRSIZE(3), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .wdata        (wdata),
    .winc         (winc),
    .rinc         (rinc),
    .rdata        (rdata),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(count), 32'(n));
    chk({tag, ":wfull"}, 32'(wfull), 32'(n == DEPTH));
    chk({tag, ":rempty"}, 32'(rempty), 32'(n == 0));
    chk({tag, ":almost_full"}, 32'(almost_full), 32'(n >= DEPTH - AF));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ov));
    chk({tag, ":underflow"}, 32'(underflow), 32'(m_uf));
`ifdef SYNC_FIFO_FWFT_EN
    if (n != 0) chk({tag, ":rdata"}, 32'(rdata), 32'(q[0]));
`else
    chk({tag, ":rdata"}, 32'(rdata), 32'(m_rdata));
`endif
  endtask

  // Applies one cycle of inputs, advances the model by the FIFO rules, then checks.
  task automatic step(input string tag, input bit w, input bit r, input logic [7:0] d, input bit f);
    bit was_full, was_empty;
    @(negedge clk);
    winc = w; rinc = r; wdata = d; flush = f;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (f) begin
      q.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
    end else begin
      if (r && !was_empty) m_rdata = q.pop_front();
      if (w && !was_full) q.push_back(d);
      if (w && was_full) m_ov = 1'b1;
      if (r && was_empty) m_uf = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_uf = 1'b0;
    m_rdata = 8'h00;
  endtask

  initial begin
    // reset state
    #12;
    check_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    // fill 1..8
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);

    // writes while full are dropped and latch overflow
    step("ovf1", 1'b1, 1'b0, 8'h55, 1'b0);
    step("ovf2", 1'b1, 1'b0, 8'h55, 1'b0);

    // drain, expecting 1..8
    for (int i = 1; i <= DEPTH; i++) begin
      step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_val", 32'(rdata), 32'(i));
    end

    // simultaneous on empty: write wins, underflow set
    step("empty_wr", 1'b1, 1'b1, 8'hA0, 1'b0);
    step("empty_rd", 1'b0, 1'b1, 8'h00, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("a0_readback", 32'(rdata), 32'h0A0);
`endif
    step("flush_uf", 1'b0, 1'b0, 8'h00, 1'b1);

    // steady state count 4 across pointer wrap
    for (int i = 0; i < 4; i++) step("pre4", 1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 20; i++) step("steady", 1'b1, 1'b1, 8'(8'h20 + i), 1'b0);

    // full with simultaneous read and write: read wins, overflow set
    for (int i = 0; i < 4; i++) step("refill", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    step("full_rw", 1'b1, 1'b1, 8'h77, 1'b0);

    // half-full with overflow, flush together with a write
    for (int i = 0; i < 3; i++) step("half", 1'b0, 1'b1, 8'h00, 1'b0);
    step("flush_wr", 1'b1, 1'b0, 8'h99, 1'b1);

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           8'($urandom), 1'($urandom_range(0, 31) == 0));

    // asynchronous reset mid-stream, checked before any clock edge
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; flush = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rstn = 1'b1;

`ifdef SYNC_FIFO_FWFT_EN
    step("fwft_w1", 1'b1, 1'b0, 8'h11, 1'b0);
    chk("fwft_first", 32'(rdata), 32'h11);
    step("fwft_w2", 1'b1, 1'b0, 8'h22, 1'b0);
    step("fwft_pop", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_second", 32'(rdata), 32'h22);
`endif

    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; flush = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
